tx_serial: RTL

TX_SERIAL -- requirements
Module: tx_serial

---
 rtl/tx_serial.sv | 100 ++++++++++
 1 files changed

// File: rtl/tx_serial.sv
// 8N1 serial transmitter: one start bit, eight data bits LSB first, one stop bit,
// followed by a single DONE cycle that pulses eoTx.
module tx_serial #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stTx,
  input  logic [7:0] data,
  output logic       tx,
  output logic       eoTx,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             baud_wrap;

  assign baud_wrap = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (stTx) state_nxt = START;
      START:   if (baud_wrap) state_nxt = DATA;
      DATA:    if (baud_wrap && idx == 3'd7) state_nxt = STOP;
      STOP:    if (baud_wrap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    eoTx = (state == DONE);
  end

  // tx is registered and always reflects the state being entered at this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          tx  <= 1'b1;
          if (stTx) begin
            shreg <= data;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_wrap) begin
            cnt <= '0;
            tx  <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            cnt   <= '0;
            idx   <= idx + 1'b1;
            shreg <= shreg >> 1;
            tx    <= (idx == 3'd7) ? 1'b1 : shreg[1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_wrap) cnt <= '0;
          else           cnt <= cnt + 1'b1;
        end
        default: begin
          cnt <= '0;
          tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule
